// File: rtl/pseudorandom_ff_pkg.sv
// -----------------------------------------------------------------------------
// pseudorandom_ff_pkg
//   Shared types, constants and helper functions for the pseudorandom
//   flip-flop stress array.
//
//   cell_t      : one 16-bit register cell / LFSR word
//   LFSR_SEED   : LFSR reset value (nonzero, so the LFSR can never lock up)
//   LFSR_TAPS   : Fibonacci tap mask, bits 15, 13, 12, 10
//   rotl1()     : rotate a cell left by one bit
//   lfsr_next() : one LFSR step (shift left, feedback into bit 0)
//   parity16()  : XOR reduction of a cell
//
//   Optional build macro used by the top level: PSEUDORANDOM_FF_ASSERT_EN
// -----------------------------------------------------------------------------
package pseudorandom_ff_pkg;

   typedef logic [15:0] cell_t;

   localparam cell_t LFSR_SEED     = 16'hACE1;
   localparam cell_t LFSR_TAPS     = 16'hB400;
   localparam int    CELL_W        = 16;
   localparam int    MIN_NUM_CELLS = 1;
   localparam int    MAX_NUM_CELLS = 1024;

   function automatic cell_t rotl1(input cell_t value);
      return {value[CELL_W-2:0], value[CELL_W-1]};
   endfunction

   // Feedback is the parity of the tapped bits; the register shifts toward
   // the MSB and the feedback bit enters at bit 0.
   function automatic cell_t lfsr_next(input cell_t value);
      logic fb;
      fb = ^(value & LFSR_TAPS);
      return {value[CELL_W-2:0], fb};
   endfunction

   function automatic logic parity16(input cell_t value);
      return ^value;
   endfunction

endpackage

// File: rtl/pseudorandom_ff_array_cell.sv
// -----------------------------------------------------------------------------
// pseudorandom_ff_cell
//   One 16-bit stress cell. Every rising edge the cell loads its own
//   value rotated left by one, XORed with the source word, so the cell keeps
//   toggling as long as its source is active.
//
//   Ports
//     clk    in   1   rising-edge clock
//     resetn in   1   asynchronous, active-low reset (cell clears to 0)
//     src    in  16   source word (LFSR or previous cell, pre-update value)
//     q      out 16   registered cell value
// -----------------------------------------------------------------------------
module pseudorandom_ff_cell
   import pseudorandom_ff_pkg::*;
(
   input  logic  clk,
   input  logic  resetn,
   input  cell_t src,
   output cell_t q
);

   // The keep attribute stops synthesis from merging or trimming these flops;
   // the whole point of the block is to have all of them toggle.
   (* keep = "true" *) cell_t q_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q_reg <= '0;
      end else begin
         q_reg <= src ^ rotl1(q_reg);
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/pseudorandom_ff_array.sv
// -----------------------------------------------------------------------------
// pseudorandom_ff_array
//   FPGA power/timing stress block. A 16-bit Fibonacci LFSR feeds a chain of
//   NUM_CELLS register cells; every cell toggles pseudorandomly every clock.
//   All cells are folded into registered dummy outputs so that no flop can be
//   optimised away. Free-running: no enable, no handshake, no FSM.
//
//   Parameters
//     NUM_CELLS      number of 16-bit cells in the chain, legal 1..1024
//
//   Ports
//     clk            in   1   rising-edge clock
//     resetn         in   1   asynchronous, active-low reset
//     dummy          out  1   parity of the XOR fold of all cells (registered)
//     dummy_address  out 16   last cell of the chain (registered)
//     dummy_data     out 16   XOR fold of all cells (registered)
//
//   Build macro
//     PSEUDORANDOM_FF_ASSERT_EN : when defined, simulation-only checks are
//       compiled in (NUM_CELLS range at elaboration, LFSR never zero while
//       out of reset). Functional behaviour is identical either way.
// -----------------------------------------------------------------------------
module pseudorandom_ff_array
   import pseudorandom_ff_pkg::*;
#(
   parameter int NUM_CELLS = 60
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        dummy,
   output logic [15:0] dummy_address,
   output logic [15:0] dummy_data
);

   cell_t lfsr;
   cell_t cell_q [NUM_CELLS];
   cell_t fold;

   // ---------------------------------------------------------------------------
   // LFSR source. Seed is nonzero and the taps give a maximal-length sequence,
   // so the register never reaches the all-zero lock-up state.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= lfsr_next(lfsr);
      end
   end

   // ---------------------------------------------------------------------------
   // Cell chain. Cell 0 is fed by the LFSR, every other cell by its
   // predecessor, so activity ripples down the chain one cell per clock.
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_CELLS; i++) begin : g_chain
      if (i == 0) begin : g_head
         pseudorandom_ff_cell u_cell (
            .clk    (clk),
            .resetn (resetn),
            .src    (lfsr),
            .q      (cell_q[i])
         );
      end else begin : g_link
         pseudorandom_ff_cell u_cell (
            .clk    (clk),
            .resetn (resetn),
            .src    (cell_q[i-1]),
            .q      (cell_q[i])
         );
      end
   end

   // ---------------------------------------------------------------------------
   // XOR fold of every cell: one combinational reduction tree that makes every
   // cell flop observable at the outputs.
   // ---------------------------------------------------------------------------
   always_comb begin
      fold = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         fold = fold ^ cell_q[i];
      end
   end

   // ---------------------------------------------------------------------------
   // Output registers, loaded from the pre-update cell values.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dummy         <= 1'b0;
         dummy_address <= '0;
         dummy_data    <= '0;
      end else begin
         dummy         <= parity16(fold);
         dummy_address <= cell_q[NUM_CELLS-1];
         dummy_data    <= fold;
      end
   end

`ifdef PSEUDORANDOM_FF_ASSERT_EN
   // Simulation-only sanity checks.
   if ((NUM_CELLS < MIN_NUM_CELLS) || (NUM_CELLS > MAX_NUM_CELLS)) begin : g_bad_num_cells
      $error("pseudorandom_ff_array: NUM_CELLS=%0d outside %0d..%0d",
             NUM_CELLS, MIN_NUM_CELLS, MAX_NUM_CELLS);
   end

   always @(posedge clk) begin
      if (resetn) begin
         assert (lfsr != '0)
         else $error("pseudorandom_ff_array: LFSR reached the all-zero state");
      end
   end
`endif

endmodule

// File: tb/tb_pseudorandom_ff_array.sv
// -----------------------------------------------------------------------------
// tb_pseudorandom_ff_array
//   Two instances share clock and reset: a 60-cell array and a 1-cell array.
//   A behavioural model of the LFSR, the cell recurrences and the output fold
//   predicts every output on every clock; the predictions go through an
//   expected queue and are checked half a cycle after each rising edge.
//   Directed checks cover reset values, the first LFSR steps, the chain
//   latency, the single-cell case, an asynchronous mid-run reset and the
//   output activity level. Reset hold lengths and run lengths are random.
// -----------------------------------------------------------------------------
module tb_pseudorandom_ff_array;

   localparam int N_BIG = 60;
   localparam logic [15:0] SEED = 16'hACE1;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic        dummy_big, dummy_one;
   logic [15:0] addr_big, addr_one, data_big, data_one;

   pseudorandom_ff_array #(.NUM_CELLS(N_BIG)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .dummy         (dummy_big),
      .dummy_address (addr_big),
      .dummy_data    (data_big)
   );

   pseudorandom_ff_array #(.NUM_CELLS(1)) dut1 (
      .clk           (clk),
      .resetn        (resetn),
      .dummy         (dummy_one),
      .dummy_address (addr_one),
      .dummy_data    (data_one)
   );

   // ---------------------------------------------------------------------------
   // Check task and counters
   // ---------------------------------------------------------------------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: arrays of cell words advanced by the stated recurrences.
   // ---------------------------------------------------------------------------
   logic [15:0] m_lfsr = SEED;
   logic [15:0] m_cell [N_BIG];
   logic [15:0] m_one  = '0;
   logic [15:0] m_addr = '0, m_data = '0, m1_addr = '0, m1_data = '0;
   logic        m_dummy = 1'b0, m1_dummy = 1'b0;

   // Packed expectation: {dummy1, addr1, data1, dummy, addr, data}
   logic [65:0] exp_q[$];

   function automatic logic [15:0] rot_left(input logic [15:0] x);
      return (x << 1) | (x >> 15);
   endfunction

   task automatic model_reset();
      m_lfsr = SEED;
      foreach (m_cell[i]) m_cell[i] = '0;
      m_one = '0;
      m_addr = '0; m_data = '0; m_dummy = 1'b0;
      m_one  = '0; m1_addr = '0; m1_data = '0; m1_dummy = 1'b0;
   endtask

   task automatic model_step();
      logic [15:0] fold;
      fold = '0;
      foreach (m_cell[i]) fold ^= m_cell[i];
      m_addr  = m_cell[N_BIG-1];
      m_data  = fold;
      m_dummy = ^fold;
      m1_addr  = m_one;
      m1_data  = m_one;
      m1_dummy = ^m_one;
      // Walk from the tail so each cell still sees its predecessor's old value.
      for (int i = N_BIG-1; i >= 1; i--) m_cell[i] = m_cell[i-1] ^ rot_left(m_cell[i]);
      m_cell[0] = m_lfsr ^ rot_left(m_cell[0]);
      m_one     = m_lfsr ^ rot_left(m_one);
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   endtask

   initial model_reset();

   always @(negedge resetn) model_reset();

   always @(posedge clk) begin
      if (!resetn) model_reset();
      else         model_step();
      exp_q.push_back({m1_dummy, m1_addr, m1_data, m_dummy, m_addr, m_data});
   end

   // ---------------------------------------------------------------------------
   // Scoreboard: compare on the falling edge, away from the active edge.
   // ---------------------------------------------------------------------------
   int toggles = 0;
   int x_seen  = 0;
   logic prev_dummy = 1'b0;

   always @(negedge clk) begin
      logic [65:0] e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (!resetn) e = '0;   // asynchronous reset overrides the queued value
         check("big_dummy", 64'(dummy_big), 64'(e[32]));
         check("big_addr",  64'(addr_big),  64'(e[31:16]));
         check("big_data",  64'(data_big),  64'(e[15:0]));
         check("one_dummy", 64'(dummy_one), 64'(e[65]));
         check("one_addr",  64'(addr_one),  64'(e[64:49]));
         check("one_data",  64'(data_one),  64'(e[48:33]));
      end
      if ($isunknown({dummy_big, addr_big, data_big, dummy_one, addr_one, data_one})) x_seen++;
      if (resetn && (dummy_big !== prev_dummy)) toggles++;
      prev_dummy = dummy_big;
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic check_all_zero(input string tag);
      check({tag, "_dummy"}, 64'(dummy_big), 64'd0);
      check({tag, "_addr"},  64'(addr_big),  64'd0);
      check({tag, "_data"},  64'(data_big),  64'd0);
      check({tag, "_dummy1"}, 64'(dummy_one), 64'd0);
      check({tag, "_addr1"},  64'(addr_one),  64'd0);
      check({tag, "_data1"},  64'(data_one),  64'd0);
      check({tag, "_lfsr"},  64'(dut.lfsr),  64'(SEED));
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2 resetn = 1'b1;
   endtask

   // Edge-by-edge checks from release: first LFSR steps, single-cell result,
   // and the chain latency of the 60-cell array.
   task automatic after_release_checks();
      logic [15:0] seed_v;
      seed_v = SEED;
      for (int edge_n = 1; edge_n <= N_BIG + 1; edge_n++) begin
         @(posedge clk);
         #1;
         if (edge_n == 1) begin
            check("lfsr_step1", 64'(dut.lfsr), 64'h59C3);
            check("cell0_step1", 64'(dut.cell_q[0]), 64'(SEED));
            check("data_step1", 64'(data_big), 64'd0);
         end
         if (edge_n == 2) begin
            check("data_step2", 64'(data_big), 64'(SEED));
            check("one_addr_step2", 64'(addr_one), 64'(SEED));
            check("one_data_step2", 64'(data_one), 64'(SEED));
            check("one_dummy_step2", 64'(dummy_one), 64'(^seed_v));
         end
         if (edge_n <= N_BIG) check("addr_latency_zero", 64'(addr_big), 64'd0);
         else                 check("addr_latency_live", 64'(addr_big != 16'd0), 64'd1);
      end
   endtask

   task automatic async_reset_midrun();
      @(posedge clk);
      #2 resetn = 1'b0;
      #1 check_all_zero("async_rst");
      repeat ($urandom_range(1, 6)) @(negedge clk);
      release_reset();
      after_release_checks();
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      int t0;
      repeat (5) @(posedge clk);
      #1 check_all_zero("reset");

      release_reset();
      after_release_checks();

      // Activity window on the 60-cell instance.
      t0 = toggles;
      repeat (5000) @(posedge clk);
      check("activity_ge_1000", 64'((toggles - t0) >= 1000), 64'd1);
      check("no_x", 64'(x_seen), 64'd0);

      // Random run lengths between asynchronous resets.
      for (int k = 0; k < 4; k++) begin
         async_reset_midrun();
         repeat ($urandom_range(20, 400)) @(posedge clk);
      end

      @(negedge clk);
      #1;
      check("no_x_final", 64'(x_seen), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
